// File: rtl/stepper_pkg.sv
// Shared state encoding and coil phase tables for the blind/door stepper.
// Define HALF_STEP_EN for the 8-entry half-step table; otherwise 4-entry full-step.
package stepper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_HOMING,
    ST_SETTLE,
    ST_FAULT
  } state_e;

`ifdef HALF_STEP_EN
  localparam int unsigned PHASE_N = 8;
`else
  localparam int unsigned PHASE_N = 4;
`endif
  localparam int unsigned PHASE_W = $clog2(PHASE_N);

  typedef logic [PHASE_W-1:0] phase_t;

  function automatic logic [3:0] phase_pattern(input phase_t idx);
    logic [3:0] pat;
`ifdef HALF_STEP_EN
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
`else
    case (idx)
      2'd0:    pat = 4'b1100;
      2'd1:    pat = 4'b0110;
      2'd2:    pat = 4'b0011;
      default: pat = 4'b1001;
    endcase
`endif
    return pat;
  endfunction

endpackage

// File: rtl/stepper_phase_gen.sv
// Coil phase index with advance/retreat; drives the coil pattern while enabled.
// Table size follows HALF_STEP_EN through stepper_pkg.
module stepper_phase_gen
  import stepper_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       advance_i,
  input  logic       retreat_i,
  input  logic       enable_i,
  output logic [3:0] step_out_o
);

  phase_t phase_q, phase_d;

  // Table length is a power of two, so the index wraps naturally in both directions.
  always_comb begin
    phase_d = phase_q;
    if (advance_i)      phase_d = phase_q + PHASE_W'(1);
    else if (retreat_i) phase_d = phase_q - PHASE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end

  assign step_out_o = enable_i ? phase_pattern(phase_q) : 4'b0000;

endmodule

// File: rtl/blind_motion_sequencer.sv
// Motion sequencer: arbitrates buttons, homing and auto go-to onto one 4-coil stepper.
// Build option: HALF_STEP_EN selects half-step coil sequencing (see stepper_pkg).
module blind_motion_sequencer
  import stepper_pkg::*;
#(
  parameter int unsigned STEP_DIV       = 50_000,
  parameter int unsigned POS_W          = 12,
  parameter int unsigned SETTLE_CYC     = 500_000,
  parameter int unsigned MAX_HOME_STEPS = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_Up,
  input  logic             btn_Down,
  input  logic             stop_Up,
  input  logic             stop_Down,
  input  logic             home_req,
  input  logic             auto_req,
  input  logic [POS_W-1:0] auto_target,
  output logic             auto_busy,
  output logic             auto_done,
  output logic             auto_abort,
  output logic             auto_err,
  output logic [POS_W-1:0] position,
  output logic             homed,
  output logic             fault,
  output logic [3:0]       step_out
);

  localparam int unsigned DIV_W  = $clog2(STEP_DIV + 1);
  localparam int unsigned SET_W  = $clog2(SETTLE_CYC + 1);
  localparam int unsigned HCNT_W = $clog2(MAX_HOME_STEPS + 1);
  localparam logic [POS_W-1:0] POS_MAX = '1;

  // Panel inputs are active-low; synchronisers reset to the released level.
  logic [3:0] sync1_q, sync2_q;
  logic       up_btn, dn_btn, up_lim, dn_lim;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {btn_Up, btn_Down, stop_Up, stop_Down};
      sync2_q <= sync1_q;
    end
  end

  assign up_btn = ~sync2_q[3];
  assign dn_btn = ~sync2_q[2];
  assign up_lim = ~sync2_q[1];
  assign dn_lim = ~sync2_q[0];

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [POS_W-1:0]  pos_q, pos_d, target_q, target_d, pos_inc, pos_dec;
  logic homed_q, homed_d, fault_q, fault_d, busy_q, busy_d;
  logic done_q, done_d, abort_q, abort_d, err_q, err_d;
  logic tick, step_up, step_dn, coils_on;

  assign tick    = (div_q == DIV_W'(STEP_DIV - 1));
  assign pos_inc = (pos_q == POS_MAX) ? pos_q : pos_q + 1'b1;
  assign pos_dec = (pos_q == '0)      ? pos_q : pos_q - 1'b1;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    div_d    = '0;
    settle_d = '0;
    hcnt_d   = hcnt_q;
    pos_d    = pos_q;
    target_d = target_q;
    homed_d  = homed_q;
    fault_d  = fault_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    err_d    = auto_req && (state_q != ST_IDLE);
    step_up  = 1'b0;
    step_dn  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Both buttons pressed together count as neither.
        if (up_btn && !dn_btn) begin
          if (!up_lim) state_d = ST_MOVE_UP;
          err_d = auto_req;
        end else if (dn_btn && !up_btn) begin
          if (!dn_lim) state_d = ST_MOVE_DOWN;
          err_d = auto_req;
        end else if (home_req) begin
          state_d = ST_HOMING;
          hcnt_d  = '0;
          err_d   = auto_req;
        end else if (auto_req) begin
          if (!homed_q) begin
            err_d = 1'b1;
          end else if (auto_target == pos_q) begin
            done_d = 1'b1;
          end else begin
            target_d = auto_target;
            busy_d   = 1'b1;
            state_d  = (auto_target > pos_q) ? ST_MOVE_UP : ST_MOVE_DOWN;
          end
        end
      end

      ST_MOVE_UP: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (up_lim) begin
          state_d = ST_SETTLE;
          busy_d  = 1'b0;
          done_d  = busy_q && (pos_q == target_q);
          abort_d = busy_q && (pos_q != target_q);
        end else if (busy_q ? (up_btn || dn_btn) : !up_btn) begin
          state_d = ST_SETTLE;
          abort_d = busy_q;
          busy_d  = 1'b0;
        end else if (tick) begin
          step_up = 1'b1;
          pos_d   = pos_inc;
          if (busy_q && (pos_inc == target_q)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_SETTLE;
          end
        end
      end

      ST_MOVE_DOWN: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (dn_lim) begin
          state_d = ST_SETTLE;
          pos_d   = '0;
          homed_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = busy_q && (target_q == '0);
          abort_d = busy_q && (target_q != '0);
        end else if (busy_q ? (up_btn || dn_btn) : !dn_btn) begin
          state_d = ST_SETTLE;
          abort_d = busy_q;
          busy_d  = 1'b0;
        end else if (tick) begin
          step_dn = 1'b1;
          pos_d   = pos_dec;
          if (busy_q && (pos_dec == target_q)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_SETTLE;
          end
        end
      end

      ST_HOMING: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (dn_lim) begin
          state_d = ST_SETTLE;
          pos_d   = '0;
          homed_d = 1'b1;
        end else if (tick) begin
          // The step attempt after the last allowed one gives up instead of stepping.
          if (hcnt_q == HCNT_W'(MAX_HOME_STEPS)) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
            homed_d = 1'b0;
          end else begin
            hcnt_d  = hcnt_q + 1'b1;
            step_dn = 1'b1;
            pos_d   = pos_dec;
          end
        end
      end

      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC - 1)) state_d = ST_IDLE;
        else                                   settle_d = settle_q + 1'b1;
      end

      ST_FAULT: ;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      settle_q <= '0;
      hcnt_q   <= '0;
      pos_q    <= '0;
      target_q <= '0;
      homed_q  <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      settle_q <= settle_d;
      hcnt_q   <= hcnt_d;
      pos_q    <= pos_d;
      target_q <= target_d;
      homed_q  <= homed_d;
      fault_q  <= fault_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
    end
  end

  assign coils_on = (state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DOWN) ||
                    (state_q == ST_HOMING)  || (state_q == ST_SETTLE);

  stepper_phase_gen u_phase (
    .clk        (clk),
    .rst        (rst),
    .advance_i  (step_up),
    .retreat_i  (step_dn),
    .enable_i   (coils_on),
    .step_out_o (step_out)
  );

  assign auto_busy  = busy_q;
  assign auto_done  = done_q;
  assign auto_abort = abort_q;
  assign auto_err   = err_q;
  assign position   = pos_q;
  assign homed      = homed_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_blind_motion_sequencer.sv
// Directed bench for blind_motion_sequencer (full-step build, small timing parameters).
module tb_blind_motion_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_Up, btn_Down, stop_Up, stop_Down;
  logic       home_req, auto_req;
  logic [7:0] auto_target;
  logic       auto_busy, auto_done, auto_abort, auto_err;
  logic [7:0] position;
  logic       homed, fault;
  logic [3:0] step_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blind_motion_sequencer #(
    .STEP_DIV       (4),
    .POS_W          (8),
    .SETTLE_CYC     (8),
    .MAX_HOME_STEPS (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_Up      (btn_Up),
    .btn_Down    (btn_Down),
    .stop_Up     (stop_Up),
    .stop_Down   (stop_Down),
    .home_req    (home_req),
    .auto_req    (auto_req),
    .auto_target (auto_target),
    .auto_busy   (auto_busy),
    .auto_done   (auto_done),
    .auto_abort  (auto_abort),
    .auto_err    (auto_err),
    .position    (position),
    .homed       (homed),
    .fault       (fault),
    .step_out    (step_out)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; btn_Up = 1'b1; btn_Down = 1'b1; stop_Up = 1'b1; stop_Down = 1'b1;
    home_req = 1'b0; auto_req = 1'b0; auto_target = 8'd0;
    cyc(3);
    check("rst_position", position, 0);
    check("rst_homed", homed, 0);
    check("rst_fault", fault, 0);
    check("rst_step_out", step_out, 4'b0000);
    check("rst_busy", auto_busy, 0);
    check("rst_pulses", {auto_done, auto_abort, auto_err}, 3'b000);
    rst = 1'b0;
    cyc(1);

    // 1: auto request before homing is rejected
    auto_target = 8'd5; auto_req = 1'b1;
    cyc(1);
    auto_req = 1'b0;
    check("t1_err_pulse", auto_err, 1);
    check("t1_step_out", step_out, 4'b0000);
    cyc(1);
    check("t1_err_clear", auto_err, 0);
    check("t1_homed", homed, 0);
    check("t1_busy", auto_busy, 0);

    // 2: homing, limit after three down steps (phase 0 -> 3 -> 2 -> 1)
    home_req = 1'b1;
    cyc(1);
    home_req = 1'b0;
    check("t2_entry_coils", step_out, 4'b1100);
    cyc(11);
    check("t2_step2", step_out, 4'b0011);
    cyc(1);
    check("t2_step3", step_out, 4'b0110);
    stop_Down = 1'b0;
    cyc(2);
    check("t2_sync_latency", homed, 0);
    cyc(1);
    check("t2_homed", homed, 1);
    check("t2_position", position, 0);
    check("t2_settle_hold", step_out, 4'b0110);
    cyc(7);
    check("t2_settle_end", step_out, 4'b0110);
    cyc(1);
    check("t2_idle_coils", step_out, 4'b0000);
    stop_Down = 1'b1;

    // 3: auto move 0 -> 6, one step every 4 cycles
    auto_target = 8'd6; auto_req = 1'b1;
    cyc(1);
    auto_req = 1'b0;
    check("t3_busy", auto_busy, 1);
    check("t3_start_pos", position, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(4);
      check($sformatf("t3_pos%0d", k), position, k);
      check($sformatf("t3_done%0d", k), auto_done, (k == 6) ? 1 : 0);
    end
    check("t3_busy_low", auto_busy, 0);
    check("t3_coils", step_out, 4'b1001);
    cyc(1);
    check("t3_done_once", auto_done, 0);
    cyc(7);
    check("t3_idle", step_out, 4'b0000);

    // 4: auto 6 -> 10 aborted by btn_Down after 2 steps, then manual down
    auto_target = 8'd10; auto_req = 1'b1;
    cyc(1);
    auto_req = 1'b0;
    check("t4_busy", auto_busy, 1);
    cyc(4);
    check("t4_pos7", position, 7);
    cyc(4);
    check("t4_pos8", position, 8);
    btn_Down = 1'b0;
    cyc(3);
    check("t4_abort", auto_abort, 1);
    check("t4_busy_low", auto_busy, 0);
    check("t4_abort_pos", position, 8);
    cyc(1);
    check("t4_abort_once", auto_abort, 0);
    cyc(7);
    check("t4_idle_after_settle", step_out, 4'b0000);
    cyc(1);
    check("t4_move_down_coils", step_out, 4'b0110);
    cyc(3);
    check("t4_pre_step", position, 8);
    cyc(1);
    check("t4_down_step", position, 7);
    check("t4_down_coils", step_out, 4'b1100);
    btn_Down = 1'b1;
    cyc(4);
    check("t4_release_pos", position, 7);
    cyc(7);
    check("t4_idle", step_out, 4'b0000);

    // 5: manual up into upper limit, then retry against the limit
    btn_Up = 1'b0;
    cyc(3);
    check("t5_move_coils", step_out, 4'b1100);
    cyc(4);
    check("t5_pos8", position, 8);
    cyc(4);
    check("t5_pos9", position, 9);
    cyc(1);
    stop_Up = 1'b0;
    cyc(3);
    check("t5_limit_no_step", position, 9);
    check("t5_settle_coils", step_out, 4'b0011);
    cyc(4);
    check("t5_still_stopped", position, 9);
    cyc(4);
    check("t5_idle_coils", step_out, 4'b0000);
    cyc(8);
    check("t5_retry_idle", step_out, 4'b0000);
    check("t5_retry_pos", position, 9);
    btn_Up = 1'b1; stop_Up = 1'b1;
    cyc(3);

    // 6: homing without limit faults on the 21st step attempt
    home_req = 1'b1;
    cyc(1);
    home_req = 1'b0;
    cyc(80);
    check("t6_pos_floor", position, 0);
    check("t6_coils", step_out, 4'b0011);
    cyc(3);
    check("t6_no_fault_yet", fault, 0);
    check("t6_homed_kept", homed, 1);
    cyc(1);
    check("t6_fault", fault, 1);
    check("t6_homed_lost", homed, 0);
    check("t6_coils_off", step_out, 4'b0000);
    auto_target = 8'd3; auto_req = 1'b1;
    cyc(1);
    auto_req = 1'b0;
    check("t6_err_in_fault", auto_err, 1);
    btn_Down = 1'b0;
    cyc(10);
    check("t6_fault_sticky", fault, 1);
    check("t6_fault_coils", step_out, 4'b0000);
    btn_Down = 1'b1;
    rst = 1'b1;
    cyc(1);
    check("t6_rst_fault", fault, 0);
    check("t6_rst_pos", position, 0);
    rst = 1'b0;
    cyc(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
